ram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data/instruction RAM. It sits between the CPU memory interface (MAR/MDR path, requester 0) and the boot loader / debug port (requester 1), and grants the RAM to one requester at a time with round-robin fairness. It handles programmable RAM wait states, byte-lane writes and a registered read-data return.

---
 rtl/ram_port_arbiter_if.sv | 35 +++
 rtl/ram_port_arbiter.sv | 77 +++++++
 tb/tb_ram_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester, RAM and status bundle of the RAM port arbiter
// Ports: m0_*/m1_* requester buses (req/we/addr/wdata/be in, ack out), rdata,
//        ram_* RAM side (addr/wdata/we/be out, rdata in), busy and owner status.
//        slave = arbiter view, master = requester/RAM environment view.
interface ram_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic            m0_req, m1_req;
    logic            m0_we, m1_we;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic [DW-1:0]   m0_wdata, m1_wdata;
    logic [DW/8-1:0] m0_be, m1_be;
    logic            m0_ack, m1_ack;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic            ram_we;
    logic [DW/8-1:0] ram_be;
    logic [DW-1:0]   ram_rdata;
    logic            busy;
    logic            owner;
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_be, m1_be, ram_rdata,
        output m0_ack, m1_ack, rdata, ram_addr, ram_wdata, ram_we, ram_be,
               busy, owner
    );
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_be, m1_be, ram_rdata,
        input  m0_ack, m1_ack, rdata, ram_addr, ram_wdata, ram_we, ram_be,
               busy, owner
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-requester sequencer for the single-port RAM
// Ports: clk, reset (sync, active-high); bus (slave) carries both requester
//        buses, the RAM address/data/strobe side, rdata, busy and owner.
module ram_port_arbiter #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int WAIT = 1
) (
    input logic            clk,
    input logic            reset,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t          state, state_n;
    logic            grant, owner, last_owner, h_we, ram_we, m0_ack, m1_ack;
    logic [2:0]      cnt;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata, rdata;
    logic [DW/8-1:0] ram_be;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        grant = bus.m1_req & (~bus.m0_req | ~last_owner);
        if (state == IDLE && (bus.m0_req || bus.m1_req)) state_n = ACCESS;
        if (state == ACCESS && cnt == 3'd0) state_n = RESP;
        if (state == RESP) state_n = IDLE;
    end
    // The ram_* registers double as the holding registers of the granted access.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_be     <= '0;
            ram_we     <= 1'b0;
            h_we       <= 1'b0;
            rdata      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= 3'd0;
        end else begin
            ram_we <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (state == IDLE && (bus.m0_req || bus.m1_req)) begin
                ram_addr   <= grant ? bus.m1_addr : bus.m0_addr;
                ram_wdata  <= grant ? bus.m1_wdata : bus.m0_wdata;
                ram_be     <= grant ? bus.m1_be : bus.m0_be;
                h_we       <= grant ? bus.m1_we : bus.m0_we;
                // Strobe only in the first ACCESS cycle; an all-zero be write is a no-op.
                ram_we     <= grant ? bus.m1_we && bus.m1_be != '0 : bus.m0_we && bus.m0_be != '0;
                owner      <= grant;
                last_owner <= grant;
                cnt        <= 3'(WAIT);
            end
            if (state == ACCESS) begin
                cnt <= cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
                if (cnt == 3'd0) begin
                    m0_ack <= ~owner;
                    m1_ack <= owner;
                    if (!h_we) rdata <= bus.ram_rdata;
                end
            end
        end
    end
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.ram_be    = ram_be;
    assign bus.ram_we    = ram_we;
    assign bus.rdata     = rdata;
    assign bus.m0_ack    = m0_ack;
    assign bus.m1_ack    = m1_ack;
    assign bus.owner     = owner;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table, directed and randomized checks of ram_port_arbiter
module tb_ram_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int W  = 2;
    typedef struct {
        bit          r0, r1;
        bit          we0, we1;
        logic [15:0] a0, a1, wd0, wd1;
        logic [1:0]  be0, be1;
        bit          first;
        logic [15:0] rd0, rd1;
        int          wrs;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] mem [0:1023];
    logic [15:0] ref_mem [0:1023];
    bit m_last;
    vec_t tbl [8];
    vec_t cv;
    always #5 clk = ~clk;
    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
    ram_port_arbiter #(.AW(AW), .DW(DW), .WAIT(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    function automatic logic [15:0] init_val(input int a);
        return a == 64 ? 16'hBEEF : a == 65 ? 16'h1234 : a == 256 ? 16'h0000 : 16'(a * 257) ^ 16'h5A3C;
    endfunction
    assign bus.ram_rdata = mem[bus.ram_addr[9:0]];
    always @(posedge clk)
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (bus.ram_we) begin
            if (bus.ram_be[0]) mem[bus.ram_addr[9:0]][7:0] <= bus.ram_wdata[7:0];
            if (bus.ram_be[1]) mem[bus.ram_addr[9:0]][15:8] <= bus.ram_wdata[15:8];
        end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic model_reset();
        m_last = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    endtask
    // Spec-level model: pick the winner by the round-robin rule, then perform
    // the accesses in grant order on a shadow memory.
    task automatic predict(inout vec_t v);
        int n;
        bit g;
        logic we;
        logic [15:0] a, wd;
        logic [1:0] be;
        v.wrs = 0;
        v.rd0 = '0;
        v.rd1 = '0;
        v.first = (v.r0 && v.r1) ? ~m_last : v.r1;
        n = (v.r0 && v.r1) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            g  = (k == 0) ? v.first : ~v.first;
            we = g ? v.we1 : v.we0;
            a  = g ? v.a1 : v.a0;
            wd = g ? v.wd1 : v.wd0;
            be = g ? v.be1 : v.be0;
            if (we) begin
                if (be != 2'b00) v.wrs++;
                if (be[0]) ref_mem[a[9:0]][7:0] = wd[7:0];
                if (be[1]) ref_mem[a[9:0]][15:8] = wd[15:8];
            end else if (g) v.rd1 = ref_mem[a[9:0]];
            else v.rd0 = ref_mem[a[9:0]];
            m_last = g;
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " acks"}, {bus.m0_ack, bus.m1_ack}, 0);
        chk({tag, " ram_we"}, 32'(bus.ram_we), 0);
        chk({tag, " ram_addr"}, 32'(bus.ram_addr), 0);
        chk({tag, " ram_wdata"}, 32'(bus.ram_wdata), 0);
        chk({tag, " ram_be"}, 32'(bus.ram_be), 0);
        chk({tag, " rdata"}, 32'(bus.rdata), 0);
        chk({tag, " owner"}, 32'(bus.owner), 0);
    endtask
    task automatic run(input vec_t v, input string tag);
        int n, got0, got1, wrs;
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(bus.busy), 0);
        chk({tag, " idle acks"}, {bus.m0_ack, bus.m1_ack}, 0);
        bus.m0_req = v.r0; bus.m0_we = v.we0; bus.m0_addr = v.a0; bus.m0_wdata = v.wd0; bus.m0_be = v.be0;
        bus.m1_req = v.r1; bus.m1_we = v.we1; bus.m1_addr = v.a1; bus.m1_wdata = v.wd1; bus.m1_be = v.be1;
        n = 0; got0 = -1; got1 = -1; wrs = 0;
        while ((v.r0 && got0 < 0) || (v.r1 && got1 < 0)) begin
            @(negedge clk);
            n++;
            if (n > 4 * W + 12) begin
                errors++;
                $display("FAIL %s timeout: got0 %0d got1 %0d required both acks", tag, got0, got1);
                break;
            end
            if (bus.ram_we) begin
                wrs++;
                chk({tag, " wr addr"}, 32'(bus.ram_addr), 32'(bus.owner ? v.a1 : v.a0));
                chk({tag, " wr data"}, 32'(bus.ram_wdata), 32'(bus.owner ? v.wd1 : v.wd0));
                chk({tag, " wr be"}, 32'(bus.ram_be), 32'(bus.owner ? v.be1 : v.be0));
            end
            if (bus.m0_ack) begin
                chk({tag, " m0_ack expected"}, 32'(v.r0 && got0 < 0), 1);
                got0 = n;
                bus.m0_req = 1'b0;
                if (!v.we0) chk({tag, " m0 rdata"}, 32'(bus.rdata), 32'(v.rd0));
            end
            if (bus.m1_ack) begin
                chk({tag, " m1_ack expected"}, 32'(v.r1 && got1 < 0), 1);
                got1 = n;
                bus.m1_req = 1'b0;
                if (!v.we1) chk({tag, " m1 rdata"}, 32'(bus.rdata), 32'(v.rd1));
            end
        end
        chk({tag, " first latency"}, v.first ? got1 : got0, W + 2);
        if (v.r0 && v.r1) chk({tag, " second latency"}, v.first ? got0 : got1, 2 * W + 5);
        chk({tag, " write strobes"}, wrs, v.wrs);
    endtask
    initial begin
        int n, k, seen;
        tbl[0] = '{1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 2'b11, 2'b00, 0, 16'hBEEF, 16'h0000, 0};
        tbl[1] = '{0, 1, 0, 1, 16'h0000, 16'h0100, 16'h0000, 16'h12AB, 2'b00, 2'b01, 1, 16'h0000, 16'h0000, 1};
        tbl[2] = '{1, 0, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 2'b11, 2'b00, 0, 16'h00AB, 16'h0000, 0};
        tbl[3] = '{1, 1, 1, 0, 16'h0041, 16'h0041, 16'h5566, 16'h0000, 2'b10, 2'b11, 1, 16'h0000, 16'h1234, 1};
        tbl[4] = '{1, 1, 0, 1, 16'h0041, 16'h0040, 16'h0000, 16'h0000, 2'b11, 2'b00, 1, 16'h5534, 16'h0000, 0};
        tbl[5] = '{1, 0, 1, 0, 16'h0040, 16'h0000, 16'hFFFF, 16'h0000, 2'b00, 2'b00, 0, 16'h0000, 16'h0000, 0};
        tbl[6] = '{1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 2'b11, 2'b00, 0, 16'hBEEF, 16'h0000, 0};
        tbl[7] = '{1, 1, 0, 0, 16'h0040, 16'h0100, 16'h0000, 16'h0000, 2'b11, 2'b11, 1, 16'hBEEF, 16'h00AB, 0};
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_be = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_be = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        bus.m0_req = 1; bus.m0_addr = 16'h0040;
        bus.m1_req = 1; bus.m1_addr = 16'h0041;
        n = 0; k = 0;
        while (k < 4 && n < 8 * (W + 3)) begin
            @(negedge clk);
            n++;
            if (bus.m0_ack || bus.m1_ack) begin
                chk("alt who", {bus.m0_ack, bus.m1_ack}, (k % 2 == 1) ? 1 : 2);
                chk("alt time", n, W + 2 + k * (W + 3));
                chk("alt owner", 32'(bus.owner), k % 2);
                chk("alt rdata", 32'(bus.rdata), (k % 2 == 1) ? 32'h1234 : 32'hBEEF);
                k++;
            end
        end
        chk("alt grants", k, 4);
        bus.m0_req = 0; bus.m1_req = 0;
        m_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cv = tbl[i];
            predict(cv);
            run(tbl[i], $sformatf("tbl%0d", i));
        end
        @(negedge clk);
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 16'h0042;
        bus.m1_we = 0; bus.m1_addr = 16'h0043;
        for (n = 1; n <= 2 * W + 6; n++) begin
            @(negedge clk);
            if (n == 1) bus.m1_req = 1;
            chk("lc m0_ack", 32'(bus.m0_ack), 32'(n == W + 2));
            chk("lc m1_ack", 32'(bus.m1_ack), 32'(n == 2 * W + 5));
            if (bus.m0_ack) begin
                bus.m0_req = 0;
                chk("lc m0 rdata", 32'(bus.rdata), 32'(ref_mem[16'h42]));
            end
            if (bus.m1_ack) begin
                bus.m1_req = 0;
                chk("lc m1 rdata", 32'(bus.rdata), 32'(ref_mem[16'h43]));
            end
            if (n >= W + 3) begin
                bus.m0_addr = 16'($urandom); bus.m0_we = 1; bus.m0_wdata = 16'($urandom); bus.m0_be = 2'b11;
            end
            if (n >= W + 4 && n <= 2 * W + 4) begin
                chk("lc m1 addr", 32'(bus.ram_addr), 32'h0043);
                chk("lc m1 owner", 32'(bus.owner), 1);
                chk("lc no write", 32'(bus.ram_we), 0);
            end
        end
        m_last = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cv.r0 = 1'($urandom_range(0, 1)); cv.r1 = 1'($urandom_range(0, 1));
            if (!cv.r0 && !cv.r1) cv.r0 = 1;
            cv.we0 = 1'($urandom_range(0, 1)); cv.we1 = 1'($urandom_range(0, 1));
            cv.a0 = 16'(16'h0040 + $urandom_range(0, 7)); cv.a1 = 16'(16'h0040 + $urandom_range(0, 7));
            cv.wd0 = 16'($urandom); cv.wd1 = 16'($urandom);
            cv.be0 = 2'($urandom_range(0, 3)); cv.be1 = 2'($urandom_range(0, 3));
            predict(cv);
            run(cv, $sformatf("rnd%0d", i));
        end
        @(negedge clk);
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0044; bus.m0_wdata = 16'h7777; bus.m0_be = 2'b11;
        @(negedge clk);
        chk("rst first strobe", 32'(bus.ram_we), 1);
        @(negedge clk);
        chk("rst second access busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("rst mid");
        reset = 1'b0;
        bus.m0_req = 0;
        model_reset();
        seen = 0;
        repeat (2 * W + 6) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack || bus.ram_we) seen++;
        end
        chk("rst abandoned ack/strobe", seen, 0);
        cv = '{0, 1, 0, 0, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 2'b00, 2'b11, 0, 16'h0000, 16'h0000, 0};
        predict(cv);
        run(cv, "post rst");
        cv = '{1, 0, 0, 0, 16'h0044, 16'h0000, 16'h0000, 16'h0000, 2'b11, 2'b00, 0, 16'h0000, 16'h0000, 0};
        predict(cv);
        run(cv, "post rst rd");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
